// File: rtl/sprite_draw.sv
// Sprite stage: 1bpp bitmap loaded during vblank, one row fetched per line,
// registered per-pixel hit and bitmap bit against a per-frame shadowed box.
module sprite_draw #(
  parameter int SPRITE_W = 12,
  parameter int SPRITE_H = 12,
  parameter int CNT_BITS = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [CNT_BITS-1:0] hcounter,
  input  logic signed [CNT_BITS-1:0] vcounter,
  input  logic                       blank_h,
  input  logic                       blank_v,
  input  logic                       line_next,
  input  logic                       frame_next,
  input  logic [CNT_BITS-2:0]        sprite_x,
  input  logic [CNT_BITS-2:0]        sprite_y,
  input  logic [1:0]                 scale,
  input  logic                       load_valid,
  input  logic [SPRITE_W-1:0]        load_data,
  output logic                       load_ready,
  input  logic                       load_restart,
  output logic                       sprite_hit,
  output logic                       sprite_px
);
  localparam int PTR_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int DW    = CNT_BITS + 1;

  typedef enum logic {WAIT, FETCH} state_t;

  state_t                            state;
  logic [SPRITE_H-1:0][SPRITE_W-1:0] bitmap;
  logic [PTR_W-1:0]                  wr_ptr;
  logic [SPRITE_W-1:0]               linebuf;
  logic                              line_active;
  logic [CNT_BITS-2:0]               x_s, y_s;
  logic [1:0]                        scale_s;

  logic                 load_fire;
  logic signed [DW-1:0] dy, dx, lim_h, lim_w;
  logic [DW-1:0]        row_idx, col_idx;
  logic                 dy_in, dx_in, hit_c, px_bit;
  logic [SPRITE_W-1:0]  fetch_row;

  assign load_ready = blank_v & ~reset;
  assign load_fire  = load_valid & load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap <= '0;
      wr_ptr <= '0;
    end else begin
      if (load_fire)
        for (int r = 0; r < SPRITE_H; r++)
          if (wr_ptr == PTR_W'(r)) bitmap[r] <= load_data;
      // restart wins over the increment; the word still lands at the old pointer
      if (load_restart)
        wr_ptr <= '0;
      else if (load_fire)
        wr_ptr <= (wr_ptr == PTR_W'(SPRITE_H-1)) ? '0 : wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_next) begin
      x_s     <= sprite_x;
      y_s     <= sprite_y;
      scale_s <= scale;
    end
  end

  // One extra bit so negative porch counts never alias into the box
  assign dy      = $signed({vcounter[CNT_BITS-1], vcounter}) - $signed({2'b00, y_s});
  assign dx      = $signed({hcounter[CNT_BITS-1], hcounter}) - $signed({2'b00, x_s});
  assign lim_h   = DW'(SPRITE_H) << scale_s;
  assign lim_w   = DW'(SPRITE_W) << scale_s;
  assign dy_in   = ~dy[DW-1] && (dy < lim_h);
  assign dx_in   = ~dx[DW-1] && (dx < lim_w);
  assign row_idx = dy >> scale_s;
  assign col_idx = dx >> scale_s;

  always_comb begin
    fetch_row = '0;
    for (int r = 0; r < SPRITE_H; r++)
      if (row_idx == DW'(r)) fetch_row = bitmap[r];
  end

  always_comb begin
    px_bit = 1'b0;
    for (int c = 0; c < SPRITE_W; c++)
      if (col_idx == DW'(c)) px_bit = linebuf[SPRITE_W-1-c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT;
      linebuf     <= '0;
      line_active <= 1'b0;
    end else begin
      case (state)
        WAIT: if (line_next) state <= FETCH;
        FETCH: begin
          state <= WAIT;
          if (dy_in) begin
            linebuf     <= fetch_row;
            line_active <= 1'b1;
          end else begin
            line_active <= 1'b0;
          end
        end
      endcase
    end
  end

  assign hit_c = line_active & ~blank_h & ~blank_v & dx_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_hit <= 1'b0;
      sprite_px  <= 1'b0;
    end else begin
      sprite_hit <= hit_c;
      sprite_px  <= hit_c & px_bit;
    end
  end
endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: bitmap load, scale 0/2 draw, shadowing,
// mid-line reset and restart-with-write.
module tb_sprite_draw;
  logic               clk = 1'b0;
  logic               reset;
  logic signed [10:0] hcounter, vcounter;
  logic               blank_h, blank_v, line_next, frame_next;
  logic [9:0]         sprite_x, sprite_y;
  logic [1:0]         scale;
  logic               load_valid, load_ready, load_restart;
  logic [11:0]        load_data;
  logic               sprite_hit, sprite_px;

  int n_chk = 0;
  int n_fail = 0;
  int vcur = 0;

  sprite_draw #(.SPRITE_W(12), .SPRITE_H(12), .CNT_BITS(11)) dut (
    .clk(clk), .reset(reset), .hcounter(hcounter), .vcounter(vcounter),
    .blank_h(blank_h), .blank_v(blank_v), .line_next(line_next),
    .frame_next(frame_next), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .scale(scale), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_restart(load_restart),
    .sprite_hit(sprite_hit), .sprite_px(sprite_px)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic load(input logic [11:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  // line_next cycle, then the FETCH cycle with vcounter on the new line
  task automatic fetch_line(input int v);
    blank_h   = 1'b1;
    line_next = 1'b1;
    vcounter  = 11'(v - 1);
    tick();
    line_next = 1'b0;
    vcounter  = 11'(v);
    vcur      = v;
    tick();
  endtask

  task automatic pix(input int h, input logic eh, input logic ep);
    hcounter = 11'(h);
    blank_h  = 1'b0;
    tick();
    check($sformatf("v%0d h%0d hit", vcur, h), sprite_hit, eh);
    check($sformatf("v%0d h%0d px", vcur, h), sprite_px, ep);
    blank_h  = 1'b1;
  endtask

  task automatic new_frame(input int x, input int s);
    sprite_x   = 10'(x);
    scale      = 2'(s);
    frame_next = 1'b1;
    tick();
    frame_next = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hcounter = '0; vcounter = '0;
    blank_h = 1'b1; blank_v = 1'b1; line_next = 1'b0; frame_next = 1'b0;
    sprite_x = 10'd100; sprite_y = 10'd50; scale = 2'd0;
    load_valid = 1'b0; load_data = '0; load_restart = 1'b0;
    tick();
    check("rst hit", sprite_hit, 1'b0);
    check("rst px", sprite_px, 1'b0);
    check("rst ready", load_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("vblank ready", load_ready, 1'b1);

    // walking bit rows, then a 13th word that must wrap onto row 0
    for (int i = 0; i < 12; i++) load(12'h800 >> i);
    load(12'hFFF);
    blank_v = 1'b0;
    #1;
    check("active ready", load_ready, 1'b0);
    load(12'h000);  // ignored; would clobber row 1

    // scale 0, row 0 = FFF after the wrap
    fetch_line(50);
    pix(100, 1'b1, 1'b1);
    pix(111, 1'b1, 1'b1);
    pix(112, 1'b0, 1'b0);
    pix(99,  1'b0, 1'b0);
    hcounter = 11'd100; blank_h = 1'b1; tick();
    check("hblank mask hit", sprite_hit, 1'b0);
    fetch_line(51);
    pix(100, 1'b1, 1'b0);
    pix(101, 1'b1, 1'b1);
    fetch_line(62);
    pix(100, 1'b0, 1'b0);
    fetch_line(49);
    pix(100, 1'b0, 1'b0);

    // reload row 0 = 800, switch to 4x on the next frame
    blank_v = 1'b1;
    load_restart = 1'b1; tick(); load_restart = 1'b0;
    load(12'h800);
    new_frame(100, 2);
    blank_v = 1'b0;
    fetch_line(50);
    pix(100, 1'b1, 1'b1);
    pix(103, 1'b1, 1'b1);
    pix(104, 1'b1, 1'b0);
    pix(147, 1'b1, 1'b0);
    pix(148, 1'b0, 1'b0);
    pix(99,  1'b0, 1'b0);
    fetch_line(53);
    pix(103, 1'b1, 1'b1);
    fetch_line(54);
    pix(103, 1'b1, 1'b0);
    pix(104, 1'b1, 1'b1);
    pix(107, 1'b1, 1'b1);
    pix(108, 1'b1, 1'b0);
    fetch_line(97);
    pix(147, 1'b1, 1'b1);
    pix(144, 1'b1, 1'b1);
    pix(143, 1'b1, 1'b0);
    fetch_line(98);
    pix(100, 1'b0, 1'b0);

    // mid-frame move is held off until frame_next
    sprite_x = 10'd200;
    fetch_line(60);
    pix(108, 1'b1, 1'b1);
    pix(200, 1'b0, 1'b0);
    new_frame(200, 2);
    fetch_line(50);
    pix(100, 1'b0, 1'b0);
    pix(200, 1'b1, 1'b1);

    // mid-line reset: rest of line dark, bitmap cleared, next line boxes again
    new_frame(100, 0);
    fetch_line(52);
    pix(102, 1'b1, 1'b1);
    hcounter = 11'd105; blank_h = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset hit", sprite_hit, 1'b0);
    check("reset px", sprite_px, 1'b0);
    pix(106, 1'b0, 1'b0);
    pix(103, 1'b0, 1'b0);
    fetch_line(53);
    pix(100, 1'b1, 1'b0);
    pix(111, 1'b1, 1'b0);

    // restart together with an accepted write at wr_ptr=5
    blank_v = 1'b1;
    for (int i = 0; i < 5; i++) load(12'h800 >> i);
    load_restart = 1'b1;
    load(12'h0F0);
    load_restart = 1'b0;
    load(12'h00F);
    blank_v = 1'b0;
    fetch_line(55);
    pix(104, 1'b1, 1'b1);
    pix(103, 1'b1, 1'b0);
    fetch_line(56);
    pix(108, 1'b1, 1'b0);
    fetch_line(50);
    pix(111, 1'b1, 1'b1);
    pix(100, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
